ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 5000, clk cycles the host holds PS2 clock low before a request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 100000, clk cycles allowed between device clock falling edges (2 ms at 50 MHz).
REQ-003 clk  in  1  system clock, 50 MHz.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  one-cycle request to send tx_data; sampled only in IDLE.
REQ-006 tx_data  in  8  command byte, captured on accepted start.
REQ-007 busy  out  1  high from accepted start until return to IDLE.
REQ-008 done  out  1  one-cycle pulse on completion, with or without error.
REQ-009 err  out  1  registered error flag, valid with done, held until next accepted start.
REQ-010 ps2_clk_i  in  1  PS2 clock line level (asynchronous).
REQ-011 ps2_data_i  in  1  PS2 data line level (asynchronous).
REQ-012 ps2_clk_oe  out  1  1 = drive PS2 clock low, 0 = release (open-drain).
REQ-013 ps2_data_oe  out  1  1 = drive PS2 data low, 0 = release (open-drain).

Function
REQ-014 ps2_clk_i and ps2_data_i SHALL each pass through a 2-flop synchronizer; falling edge = synchronized previous 1, current 0.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL, FIN.
REQ-016 IDLE: both oe=0, busy=0; start=1 captures tx_data, clears err, computes odd parity (~^tx_data), enters INHIBIT.
REQ-017 INHIBIT: clk_oe=1 for exactly INHIBIT_CYC cycles; data_oe=1 asserted in the last cycle; then REQ.
REQ-018 REQ: clk_oe=0, data_oe=1 (start bit 0); edge counter=0; enters SHIFT.
REQ-019 SHIFT: on device falling edge n (n=1..8) drive data bit n-1, LSB first (data_oe = ~bit); edge 9 drives parity; edge 10 releases data (stop bit, data_oe=0); then ACK.
REQ-020 ACK: on next falling edge (edge 11) sample ps2_data; 1 = missing ack, set err; then WAIT_REL.
REQ-021 WAIT_REL: wait until synchronized clock and data are both 1; then FIN.
REQ-022 FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
REQ-023 start while busy SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-024 Data line SHALL change only in the cycle following a detected falling edge, never on rising edges.
REQ-025 Only one edge per cycle counted; edge counter 4 bits, never wraps within a frame.

Reset
REQ-026 rst SHALL force IDLE, clk_oe=0, data_oe=0, busy=0, done=0, err=0, counters 0, synchronizers to 1.
REQ-027 rst mid-frame SHALL release both lines in the next cycle with no done pulse.

Configuration
REQ-028 Macro PS2_TX_TIMEOUT_EN: when defined, a cycle counter reloads on every falling edge and on entry to REQ; reaching TIMEOUT_CYC in REQ, SHIFT, ACK or WAIT_REL releases both lines, sets err, enters FIN.
REQ-029 Without PS2_TX_TIMEOUT_EN no watchdog logic SHALL exist; the FSM waits indefinitely for device edges.

Verification
REQ-030 start, tx_data=0xED, device model clocks 11 edges and acks -> data bits 1,0,1,1,0,1,1,1 then parity 1, stop released; done pulse, err=0.
REQ-031 tx_data=0xFF -> parity bit 1 driven as released (data_oe=0) at edge 9; tx_data=0x00 -> parity released-high, done, err=0.
REQ-032 Device omits ack (data high at edge 11) -> done with err=1; next start clears err.
REQ-033 After start, clk_oe=1 for exactly 5000 cycles, data_oe rises in cycle 5000; second start during busy -> no effect on frame.
REQ-034 rst asserted after edge 5 -> both oe=0 next cycle, busy=0, no done pulse.
REQ-035 PS2_TX_TIMEOUT_EN defined, device stops after edge 3 -> 100000 cycles later lines released, done=1, err=1.

Source files
------------

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one
// command byte out on device clock falling edges and checks the ack. Optional macro: PS2_TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // One cycle counter serves the inhibit interval and, when enabled, the edge watchdog.
  localparam int unsigned INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W = (INH_W > TO_W) ? INH_W : TO_W;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYC - 2);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_REL, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_q, edge_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic             clk_s, data_s, fall;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};
    clk_prev_d  = clk_s;

    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    data_d    = data_q;
    par_d     = par_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (start) begin
          data_d    = tx_data;
          par_d     = ~^tx_data;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYC <= 1);
          cnt_d     = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == INH_PRE) data_oe_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = '0;
          edge_d    = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        edge_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Edges 1..8 carry data LSB first, 9 parity, 10 releases for the stop bit.
        if (fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q < 4'd8) begin
            data_oe_d = ~data_q[edge_q[2:0]];
          end else if (edge_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          edge_d  = edge_q + 4'd1;
          err_d   = data_s;
          state_d = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog: restarts on every device falling edge; expiry aborts the frame with err.
    if (state_q inside {S_REQ, S_SHIFT, S_ACK, S_WAIT_REL}) begin
      if (fall) begin
        cnt_d = '0;
      end else if (cnt_q == TO_LAST) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        err_d     = 1'b1;
        done_d    = 1'b1;
        state_d   = S_FIN;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      edge_q      <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      data_q      <= data_d;
      par_q       <= par_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Testbench for ps2_tx: open-drain bus with a PS/2 device model, table of frames and a bit scoreboard.
`timescale 1ns/1ps
module tb_ps2_tx;

  localparam int unsigned INH   = 5000;
  localparam int unsigned TB_TO = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_line = ~ps2_data_oe & dev_data;

  ps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .err(err),
    .ps2_clk_i(ps2_clk_line), .ps2_data_i(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #10 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  logic exp_oe_q[$];
  logic exp_err_q[$];

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       par;
    logic       exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue start, load the scoreboard, measure the inhibit window and poke a stray start.
  task automatic start_frame(input logic [7:0] d, input logic par, input logic e);
    int hi;
    int first;
    for (int i = 0; i < 8; i++) exp_oe_q.push_back(~d[i]);
    exp_oe_q.push_back(~par);
    exp_oe_q.push_back(1'b0);
    exp_err_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    tx_data = d;
    @(negedge clk);
    start = 1'b0;
    tx_data = ~d;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
    hi = ps2_clk_oe ? 1 : 0;
    first = (ps2_clk_oe && ps2_data_oe) ? 1 : 0;
    for (int k = 0; k < int'(INH) + 20 && ps2_clk_oe; k++) begin
      if (hi == 100) begin
        start = 1'b1;
        tx_data = 8'h3C;
      end
      @(negedge clk);
      start = 1'b0;
      if (ps2_clk_oe) begin
        hi++;
        if (ps2_data_oe && first == 0) first = hi;
      end
    end
    check("inhibit_len", 32'(hi), 32'(INH));
    check("data_oe_rise", 32'(first), 32'(INH));
    check("req_start_bit", 32'(ps2_data_oe), 32'd1);
  endtask

  // Device model: clocks n_edges falling edges, samples host data late in each low phase.
  task automatic device_clock(input int n_edges, input logic ack);
    logic exp;
    logic low_val;
    cyc(20);
    check("start_bit_held", 32'(ps2_data_oe), 32'd1);
    for (int n = 1; n <= n_edges; n++) begin
      if (n == 11 && ack) begin
        dev_data = 1'b0;
        cyc(5);
      end
      dev_clk = 1'b0;
      cyc(20);
      low_val = ps2_data_oe;
      if (n <= 10) begin
        if (exp_oe_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          exp = exp_oe_q.pop_front();
          check($sformatf("edge%0d_bit", n), 32'(low_val), 32'(exp));
        end
      end
      dev_clk = 1'b1;
      if (n == 11) begin
        dev_data = 1'b1;
      end else begin
        cyc(20);
        if (n <= 9) check($sformatf("edge%0d_stable_high", n), 32'(ps2_data_oe), 32'(low_val));
      end
    end
  endtask

  task automatic wait_done();
    int   pulses = 0;
    logic e = 1'b0;
    logic exp_e;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        e = err;
      end
    end
    check("done_pulses", 32'(pulses), 32'd1);
    exp_e = (exp_err_q.size() != 0) ? exp_err_q.pop_front() : 1'b0;
    check("err_at_done", 32'(e), 32'(exp_e));
    check("err_held", 32'(err), 32'(exp_e));
    check("busy_idle", 32'(busy), 32'd0);
    check("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hED, ack: 1'b1, par: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'hFF, ack: 1'b1, par: 1'b1, exp_err: 1'b0};
    vecs[2] = '{data: 8'h00, ack: 1'b1, par: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 8'h01, ack: 1'b0, par: 1'b0, exp_err: 1'b1};
    vecs[4] = '{data: 8'hA5, ack: 1'b1, par: 1'b1, exp_err: 1'b0};
    vecs[5] = '{data: 8'h07, ack: 1'b1, par: 1'b0, exp_err: 1'b0};

    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({busy, done, err, ps2_clk_oe, ps2_data_oe}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].data, vecs[i].par, vecs[i].exp_err);
      device_clock(11, vecs[i].ack);
      wait_done();
    end

    // Reset in the middle of a frame, after device edge 5.
    start_frame(8'h96, 1'b1, 1'b0);
    device_clock(5, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    begin
      int pulses = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (done) pulses++;
      end
      check("rst_mid_no_done", 32'(pulses), 32'd0);
    end
    exp_oe_q.delete();
    exp_err_q.delete();

`ifdef PS2_TX_TIMEOUT_EN
    // Device stalls after edge 3: watchdog must abort with err.
    start_frame(8'h3C, 1'b1, 1'b1);
    device_clock(3, 1'b1);
    begin
      int   k = 0;
      logic seen = 1'b0;
      while (!seen && k < int'(TB_TO) + 200) begin
        @(negedge clk);
        k++;
        if (done) begin
          seen = 1'b1;
          check("to_err", 32'(err), 32'd1);
          check("to_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        end
      end
      check("to_done_seen", 32'(seen), 32'd1);
      check("to_latency_window", 32'(k >= int'(TB_TO) - 60 && k <= int'(TB_TO)), 32'd1);
    end
    exp_oe_q.delete();
    exp_err_q.delete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end

endmodule
